// File: rtl/sliscp_pkg.sv
// Shared definitions for the inverse sLiSCP-light-192 engine: default sizes,
// FSM state encoding, the Simeck f() function and the constant builders.
// Helpers work on a wide word plus an explicit width so one set of functions
// serves any sub-block width up to MAX_W bits.
package sliscp_pkg;

  localparam int SLISCP_WIDTH     = 48;
  localparam int SLISCP_NUM_STEPS = 18;
  localparam int MAX_W            = 128;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef logic [MAX_W-1:0] word_t;

  // All-ones mask covering the low w bits.
  function automatic word_t width_mask(input int unsigned w);
    return (word_t'(1) << w) - word_t'(1);
  endfunction

  // Rotate left by n within a w-bit field.
  function automatic word_t rotl(input word_t x, input int unsigned n, input int unsigned w);
    word_t m;
    word_t v;
    m = width_mask(w);
    v = x & m;
    return ((v << n) | (v >> (w - n))) & m;
  endfunction

  // Simeck nonlinear function f(x) = (rotl5(x) & x) ^ rotl1(x) on w bits.
  function automatic word_t f_fn(input word_t x, input int unsigned w);
    return ((rotl(x, 5, w) & x) ^ rotl(x, 1, w)) & width_mask(w);
  endfunction

  // Round constant: all ones except the LSB, which carries the constant bit.
  function automatic word_t c_const(input logic b, input int unsigned w);
    return (width_mask(w) & ~word_t'(1)) | word_t'(b);
  endfunction

  // Step constant: ones above bit 7, then 2'b00, then the 6 constant bits.
  function automatic word_t scstep(input logic [5:0] sc, input int unsigned w);
    return (width_mask(w) & ~word_t'(8'hFF)) | word_t'(sc);
  endfunction

endpackage

// File: rtl/sliscp_inv_perm_if.sv
// Handshake and data bundle of the inverse permutation engine. The master
// side is the upstream producer, which also supplies the step constants
// looked up by step_idx; the slave side is the engine.
interface sliscp_inv_perm_if #(
  parameter int WIDTH     = 48,
  parameter int NUM_STEPS = 18
);
  localparam int SIDX_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [4*WIDTH-1:0]    sin;
  logic [7:0]            rc0;
  logic [7:0]            rc1;
  logic [7:0]            sc0;
  logic [7:0]            sc1;
  logic [SIDX_W-1:0]     step_idx;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*WIDTH-1:0]    sout;

  modport master (
    output in_valid, sin, rc0, rc1, sc0, sc1, out_ready,
    input  in_ready, step_idx, out_valid, sout
  );

  modport slave (
    input  in_valid, sin, rc0, rc1, sc0, sc1, out_ready,
    output in_ready, step_idx, out_valid, sout
  );
endinterface

// File: rtl/sliscp_inv_sb_round.sv
// One combinational inverse Simeck round on a WIDTH-bit sub-block:
// x = y', y = x' ^ f(y') ^ C(rc_bit), with x in the upper half.
module sliscp_inv_sb_round
  import sliscp_pkg::*;
#(
  parameter int WIDTH = SLISCP_WIDTH
) (
  input  logic [WIDTH-1:0] x_in,
  input  logic             rc_bit,
  output logic [WIDTH-1:0] x_out
);
  localparam int H = WIDTH / 2;
  typedef logic [H-1:0] half_t;

  half_t x_prev;
  half_t y_prev;
  half_t f_y;
  half_t c_rc;

  // Undo one forward round: the old x reappears as the new y-side input.
  always_comb begin
    x_prev = x_in[WIDTH-1:H];
    y_prev = x_in[H-1:0];
    f_y    = half_t'(f_fn(word_t'(y_prev), H));
    c_rc   = half_t'(c_const(rc_bit, H));
    x_out  = {y_prev, x_prev ^ f_y ^ c_rc};
  end
endmodule

// File: rtl/sliscp_inv_perm.sv
// Iterative inverse sLiSCP-light-192 permutation. Undoes NUM_STEPS steps in
// reverse order, one inverse Simeck round per clock (6 clocks per step).
// Optional build macro SLISCP_INV_ABORT_EN adds an abort input that returns
// a running or finished operation to IDLE.
module sliscp_inv_perm
  import sliscp_pkg::*;
#(
  parameter int WIDTH     = SLISCP_WIDTH,
  parameter int NUM_STEPS = SLISCP_NUM_STEPS
) (
  input  logic clk,
  input  logic rst,
`ifdef SLISCP_INV_ABORT_EN
  input  logic abort,
`endif
  sliscp_inv_perm_if.slave bus
);
  localparam int                SIDX_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [SIDX_W-1:0] LAST_STEP = SIDX_W'(NUM_STEPS - 1);
  localparam logic [2:0]        LAST_RND  = 3'd5;

  typedef logic [WIDTH-1:0] blk_t;

  state_t            state;
  state_t            state_nxt;
  blk_t              a0, a1, a2, a3;
  blk_t              a0_nxt, a1_nxt, a2_nxt, a3_nxt;
  logic [2:0]        rnd;
  logic [2:0]        rnd_nxt;
  logic [2:0]        rc_sel;
  logic [SIDX_W-1:0] sidx;
  logic [SIDX_W-1:0] sidx_nxt;
  blk_t              sb1_in, sb3_in;
  blk_t              sb1_out, sb3_out;
  logic              rc_bit0, rc_bit1;
  blk_t              sc0_blk, sc1_blk;
  logic              kill;
  logic              unused_sc_hi;

  // Only the low 6 bits of the step constants carry information.
  assign unused_sc_hi = ^{bus.sc0[7:6], bus.sc1[7:6]};

`ifdef SLISCP_INV_ABORT_EN
  assign kill = abort && (state != IDLE);
`else
  assign kill = 1'b0;
`endif

  // Round datapath operands: the first round of a step reads the untouched
  // a0/a2 outputs, later rounds iterate on a1/a3; round constants are
  // consumed from bit 5 down to bit 0.
  always_comb begin
    rc_sel  = LAST_RND - rnd;
    sb1_in  = (rnd == 3'd0) ? a0 : a1;
    sb3_in  = (rnd == 3'd0) ? a2 : a3;
    rc_bit0 = bus.rc0[rc_sel];
    rc_bit1 = bus.rc1[rc_sel];
    sc0_blk = blk_t'(scstep(bus.sc0[5:0], WIDTH));
    sc1_blk = blk_t'(scstep(bus.sc1[5:0], WIDTH));
  end

  sliscp_inv_sb_round #(.WIDTH(WIDTH)) u_sb1 (
    .x_in   (sb1_in),
    .rc_bit (rc_bit0),
    .x_out  (sb1_out)
  );

  sliscp_inv_sb_round #(.WIDTH(WIDTH)) u_sb3 (
    .x_in   (sb3_in),
    .rc_bit (rc_bit1),
    .x_out  (sb3_out)
  );

  // Next-state logic: load in IDLE, iterate rounds/steps in BUSY, hold in DONE.
  always_comb begin
    state_nxt = state;
    a0_nxt    = a0;
    a1_nxt    = a1;
    a2_nxt    = a2;
    a3_nxt    = a3;
    rnd_nxt   = rnd;
    sidx_nxt  = sidx;
    case (state)
      IDLE: begin
        sidx_nxt = LAST_STEP;
        if (bus.in_valid) begin
          a0_nxt    = bus.sin[4*WIDTH-1 -: WIDTH];
          a1_nxt    = bus.sin[3*WIDTH-1 -: WIDTH];
          a2_nxt    = bus.sin[2*WIDTH-1 -: WIDTH];
          a3_nxt    = bus.sin[WIDTH-1:0];
          rnd_nxt   = 3'd0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        a1_nxt = sb1_out;
        a3_nxt = sb3_out;
        // The mixing layer is undone once, alongside the first inverse round.
        if (rnd == 3'd0) begin
          a0_nxt = a3 ^ a0 ^ sc0_blk;
          a2_nxt = a1 ^ a2 ^ sc1_blk;
        end
        if (rnd == LAST_RND) begin
          rnd_nxt = 3'd0;
          if (sidx == '0) begin
            state_nxt = DONE;
          end else begin
            sidx_nxt = sidx - 1'b1;
          end
        end else begin
          rnd_nxt = rnd + 3'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
          sidx_nxt  = LAST_STEP;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset and abort both return to a clean IDLE.
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      state <= IDLE;
      a0    <= '0;
      a1    <= '0;
      a2    <= '0;
      a3    <= '0;
      rnd   <= 3'd0;
      sidx  <= LAST_STEP;
    end else begin
      state <= state_nxt;
      a0    <= a0_nxt;
      a1    <= a1_nxt;
      a2    <= a2_nxt;
      a3    <= a3_nxt;
      rnd   <= rnd_nxt;
      sidx  <= sidx_nxt;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.step_idx  = sidx;
  assign bus.sout      = {a0, a1, a2, a3};

endmodule

// File: tb/tb_sliscp_inv_perm.sv
// Directed bench for sliscp_inv_perm with a golden forward/inverse model and
// an expected-result queue. Also exercises a single-step (NUM_STEPS = 1) build.
module tb_sliscp_inv_perm;

  logic clk;
  logic rst;
  logic abort;
  logic abort1;

  sliscp_inv_perm_if #(.WIDTH(48), .NUM_STEPS(18)) bus ();
  sliscp_inv_perm_if #(.WIDTH(48), .NUM_STEPS(1))  bus1 ();

  sliscp_inv_perm #(.WIDTH(48), .NUM_STEPS(18)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef SLISCP_INV_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  sliscp_inv_perm #(.WIDTH(48), .NUM_STEPS(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
`ifdef SLISCP_INV_ABORT_EN
    .abort (abort1),
`endif
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rc0_tab [0:17];
  logic [7:0] rc1_tab [0:17];
  logic [7:0] sc0_tab [0:17];
  logic [7:0] sc1_tab [0:17];

  // External step-constant generator.
  always_comb begin
    bus.rc0 = rc0_tab[bus.step_idx];
    bus.rc1 = rc1_tab[bus.step_idx];
    bus.sc0 = sc0_tab[bus.step_idx];
    bus.sc1 = sc1_tab[bus.step_idx];
  end

  assign bus1.rc0 = 8'h00;
  assign bus1.rc1 = 8'h00;
  assign bus1.sc0 = 8'h00;
  assign bus1.sc1 = 8'h00;

  int total = 0;
  int bad   = 0;
  logic [191:0] sb_q[$];

  // ---------------- golden model ----------------
  function automatic logic [23:0] tf(input logic [23:0] x);
    return ({x[18:0], x[23:19]} & x) ^ {x[22:0], x[23]};
  endfunction

  function automatic logic [47:0] sb_fwd(input logic [47:0] v, input logic [7:0] rc);
    logic [23:0] x, y, nx;
    x = v[47:24];
    y = v[23:0];
    for (int k = 0; k < 6; k++) begin
      nx = tf(x) ^ y ^ {23'h7FFFFF, rc[k]};
      y  = x;
      x  = nx;
    end
    return {x, y};
  endfunction

  function automatic logic [47:0] sb_inv(input logic [47:0] v, input logic [7:0] rc);
    logic [23:0] x, y, px, py;
    x = v[47:24];
    y = v[23:0];
    for (int k = 5; k >= 0; k--) begin
      px = y;
      py = x ^ tf(y) ^ {23'h7FFFFF, rc[k]};
      x  = px;
      y  = py;
    end
    return {x, y};
  endfunction

  function automatic logic [47:0] scs(input logic [7:0] sc);
    return {40'hFF_FFFF_FFFF, 2'b00, sc[5:0]};
  endfunction

  function automatic logic [191:0] fwd_perm(input logic [191:0] st);
    logic [47:0] s0, s1, s2, s3, t0, t2, n1, n3;
    s0 = st[191:144];
    s1 = st[143:96];
    s2 = st[95:48];
    s3 = st[47:0];
    for (int j = 0; j < 18; j++) begin
      t0 = sb_fwd(s1, rc0_tab[j]);
      t2 = sb_fwd(s3, rc1_tab[j]);
      n3 = s0 ^ t0 ^ scs(sc0_tab[j]);
      n1 = s2 ^ t2 ^ scs(sc1_tab[j]);
      s0 = t0;
      s1 = n1;
      s2 = t2;
      s3 = n3;
    end
    return {s0, s1, s2, s3};
  endfunction

  function automatic logic [191:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [191:0] orig);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("accept_wait", 192'(bus.in_ready), 192'(1));
    bus.sin      = fwd_perm(orig);
    bus.in_valid = 1'b1;
    sb_q.push_back(orig);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_op(input int hold, input logic probe);
    int n;
    logic [191:0] exp;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("done_wait", 192'(bus.out_valid), 192'(1));
    chk("sb_nonempty", 192'(sb_q.size() != 0), 192'(1));
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    chk("sout", bus.sout, exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("bp_valid", 192'(bus.out_valid), 192'(1));
      chk("bp_sout", bus.sout, exp);
      chk("bp_in_ready", 192'(bus.in_ready), 192'(0));
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = probe;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("retire_in_ready", 192'(bus.in_ready), 192'(1));
    chk("retire_out_valid", 192'(bus.out_valid), 192'(0));
    chk("retire_step_idx", 192'(bus.step_idx), 192'(17));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [191:0] st;
    logic [47:0]  g;
    int n;

    for (int j = 0; j < 18; j++) begin
      rc0_tab[j] = 8'($urandom);
      rc1_tab[j] = 8'($urandom);
      sc0_tab[j] = 8'($urandom);
      sc1_tab[j] = 8'($urandom);
    end
    rst           = 1'b1;
    abort         = 1'b0;
    abort1        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.sin       = '0;
    bus.out_ready = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.sin      = '0;
    bus1.out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 192'(bus.in_ready), 192'(1));
    chk("rst_out_valid", 192'(bus.out_valid), 192'(0));
    chk("rst_sout", bus.sout, 192'(0));
    chk("rst_step_idx", 192'(bus.step_idx), 192'(17));
    rst = 1'b0;
    tick();

    // Latency and step_idx sequence; in_valid held high while BUSY is ignored
    st = rand_state();
    bus.sin      = fwd_perm(st);
    bus.in_valid = 1'b1;
    sb_q.push_back(st);
    tick();
    bus.sin = rand_state();
    for (int c = 1; c <= 108; c++) begin
      chk($sformatf("seq_step_idx_c%0d", c), 192'(bus.step_idx), 192'(17 - (c - 1) / 6));
      chk($sformatf("seq_out_valid_c%0d", c), 192'(bus.out_valid), 192'(0));
      if (c == 100) bus.in_valid = 1'b0;
      tick();
    end
    chk("lat_out_valid_109", 192'(bus.out_valid), 192'(1));
    // Backpressure for 10 cycles, in_valid asserted in the retiring cycle
    finish_op(10, 1'b1);

    // Single step build: zero state, zero constants
    bus1.sin      = '0;
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    n = 1;
    while (bus1.out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("one_latency", 192'(n), 192'(7));
    g = sb_inv(48'h0, 8'h00);
    chk("one_s0", 192'(bus1.sout[191:144]), 192'(48'hFFFFFFFFFF00));
    chk("one_s1", 192'(bus1.sout[143:96]), 192'(g));
    chk("one_s2", 192'(bus1.sout[95:48]), 192'(48'hFFFFFFFFFF00));
    chk("one_s3", 192'(bus1.sout[47:0]), 192'(g));
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    chk("one_retire", 192'(bus1.in_ready), 192'(1));

    // Round trip on random states
    for (int i = 0; i < 100; i++) begin
      start_op(rand_state());
      finish_op(i % 3, 1'b0);
    end

    // Mid-operation reset
    start_op(rand_state());
    for (int c = 1; c < 50; c++) tick();
    rst = 1'b1;
    tick();
    chk("mrst_in_ready", 192'(bus.in_ready), 192'(1));
    chk("mrst_out_valid", 192'(bus.out_valid), 192'(0));
    chk("mrst_sout", bus.sout, 192'(0));
    chk("mrst_step_idx", 192'(bus.step_idx), 192'(17));
    rst = 1'b0;
    sb_q.delete();
    tick();
    start_op(rand_state());
    finish_op(0, 1'b0);

`ifdef SLISCP_INV_ABORT_EN
    // Mid-operation abort
    start_op(rand_state());
    for (int c = 1; c < 50; c++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_in_ready", 192'(bus.in_ready), 192'(1));
    chk("abort_out_valid", 192'(bus.out_valid), 192'(0));
    chk("abort_sout", bus.sout, 192'(0));
    chk("abort_step_idx", 192'(bus.step_idx), 192'(17));
    sb_q.delete();
    start_op(rand_state());
    finish_op(0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
